hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard/stall controller for the 5-stage MIPS core; directly feeds the forwarding unit's stages.
//  Generates per-latch enable/flush (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) for load-use hazards, including JR.
//  Also covers dcache/icache waits, taken-branch flush and halt.
//  Load data is forwarded only from MEM, so a load in EX feeding decode costs exactly one bubble.
//  Keeps a wait/halt FSM plus saturating stall and flush performance counters.
// PARAMETERS
//  CNT_W   16   width of stall_cnt / flush_cnt (saturating)
// PORTS
//  CLK         in   1      core clock, rising edge
//  RST         in   1      asynchronous, active-high reset
//  ihit        in   1      instruction fetch complete this cycle
//  dhit        in   1      data access complete this cycle
//  dmemREN_me  in   1      load in MEM stage
//  dmemWEN_me  in   1      store in MEM stage
//  rs_de       in   5      rs field of instruction in decode
//  rt_de       in   5      rt field of instruction in decode
//  useRt_de    in   1      decode instruction reads rt as a source
//  jr_de       in   1      decode instruction is JR (reads rs)
//  regDst_ex   in   5      destination register of EX instruction
//  regWr_ex    in   1      EX instruction writes register file
//  regSrc_ex   in   2      EX writeback source; 2'b11 = dmemload
//  branch_ex   in   1      taken branch/jump resolved in EX (PC redirect)
//  halt_wb     in   1      HALT reached writeback
//  pc_en       out  1      PC update enable
//  fd_en       out  1      IF/ID latch enable
//  fd_flush    out  1      IF/ID insert bubble
//  de_en       out  1      ID/EX latch enable
//  de_flush    out  1      ID/EX insert bubble
//  em_en       out  1      EX/MEM latch enable
//  mw_en       out  1      MEM/WB latch enable
//  halted      out  1      sticky halt flag
//  stall_cnt   out  CNT_W  cycles with pc_en==0 (excluding HALT)
//  flush_cnt   out  CNT_W  cycles a branch flush was applied
// BEHAVIOUR
//  Reset: state=RUN, halted=0, counters=0.
//    While RST high, all *_en=0 and all *_flush=0.
//  States: RUN, DWAIT, HALT.
//    Outputs are combinational from state + inputs (Mealy). State and counters update on posedge CLK.
//  memop = dmemREN_me|dmemWEN_me.
//  lu = regWr_ex & regSrc_ex==2'b11 & regDst_ex!=0 & (rs_de==regDst_ex | (useRt_de & rt_de==regDst_ex)).
//    rs match covers JR as well.
//  Default (RUN, no event): all *_en=1, all *_flush=0.
//  Priority, highest first: halt_wb > dmem wait > branch_ex > lu > !ihit.
//  halt_wb (any state except reset): all *_en=0 this cycle; next state HALT; halted=1.
//    HALT is absorbing until RST, with all *_en=0 and flushes=0.
//  dmem wait (memop & !dhit): all *_en=0, flushes=0; RUN->DWAIT.
//    DWAIT holds while !dhit.
//    The cycle dhit=1 applies the normal RUN rules (pipeline advances), then next state is RUN.
//  branch_ex: pc_en=1, fd_flush=1, de_flush=1, all other en=1.
//    Applies regardless of ihit (outstanding fetch abandoned). lu is ignored (consumer is flushed).
//  lu: pc_en=0, fd_en=0, de_flush=1, em_en=mw_en=1.
//    Exactly one bubble; the next cycle the load is in MEM and forwarding resolves it.
//  !ihit only: pc_en=0, fd_flush=1, de/em/mw advance.
//  Flush vs enable: a latch with flush=1 also has en=1 (bubble loaded on the edge).
//  stall_cnt: +1 per cycle with pc_en==0 and state!=HALT and !RST; saturates at all-ones (no wrap).
//  flush_cnt: +1 per cycle branch_ex is applied; saturates at all-ones.
//  Simultaneous events: if branch_ex and memop&!dhit coincide, the wait wins.
//    EX is frozen, so branch_ex is re-presented and applied on the release cycle.
//  RST mid-wait or while halted: immediate return to RUN, counters cleared.
// TESTING
//  lw $2 in EX (regSrc_ex=11, regDst_ex=2), decode rs_de=2 -> one cycle pc_en=0, fd_en=0, de_flush=1; stall_cnt=1.
//  jr_de=1, rs_de=31 vs load regDst_ex=31 -> single bubble; same with regSrc_ex=00 -> no stall.
//  lu with regDst_ex=0, or rt match with useRt_de=0 -> no stall.
//  memop=1, dhit=0 for 3 cycles then 1 -> state DWAIT x3, all en=0; release cycle all en=1; stall_cnt=3.
//  branch_ex=1 with lu=1 and ihit=0 -> pc_en=1, fd_flush=1, de_flush=1; flush_cnt +1.
//  branch_ex during dmem wait -> no flush until the dhit cycle, then exactly one flush.
//  halt_wb=1 -> halted=1 next edge; all en=0 thereafter; RST pulse -> halted=0, counters=0.
//  Preload stall_cnt near max with forced stalls (CNT_W=4) -> holds at 4'hF.

Source files
------------

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: per-latch enables and bubbles
// for load-use, cache waits, taken branches and halt, plus saturating stall/flush counters.
module hazard_unit #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dmemREN_me,
   input  logic             dmemWEN_me,
   input  logic [4:0]       rs_de,
   input  logic [4:0]       rt_de,
   input  logic             useRt_de,
   input  logic             jr_de,
   input  logic [4:0]       regDst_ex,
   input  logic             regWr_ex,
   input  logic [1:0]       regSrc_ex,
   input  logic             branch_ex,
   input  logic             halt_wb,
   output logic             pc_en,
   output logic             fd_en,
   output logic             fd_flush,
   output logic             de_en,
   output logic             de_flush,
   output logic             em_en,
   output logic             mw_en,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      DWAIT = 2'b01,
      HALT  = 2'b10
   } state_t;

   state_t           state_r;
   logic             memop_s;
   logic             rs_hit_s;
   logic             rt_hit_s;
   logic             lu_s;
   logic             wait_s;
   logic             freeze_s;
   logic             branch_go_s;
   logic [CNT_W-1:0] cnt_max_s;
   logic [CNT_W-1:0] cnt_one_s;

   // Hazard detection: load in EX feeding a decode source, and data-memory wait.
   always_comb begin
      memop_s   = dmemREN_me | dmemWEN_me;
      // JR reads rs, so it is covered by the ordinary rs comparison.
      rs_hit_s  = (rs_de == regDst_ex) | (jr_de & (rs_de == regDst_ex));
      rt_hit_s  = useRt_de & (rt_de == regDst_ex);
      lu_s      = regWr_ex & (regSrc_ex == 2'b11) & (regDst_ex != 5'd0) & (rs_hit_s | rt_hit_s);
      wait_s    = ~dhit & (memop_s | (state_r == DWAIT));
      cnt_max_s = {CNT_W{1'b1}};
      cnt_one_s = {{(CNT_W-1){1'b0}}, 1'b1};
      case (state_r)
         RUN, DWAIT: freeze_s = RST | halt_wb | wait_s;
         default:    freeze_s = 1'b1;
      endcase
   end

   // Mealy enable/flush decode, highest-priority event first.
   always_comb begin
      pc_en       = 1'b1;
      fd_en       = 1'b1;
      fd_flush    = 1'b0;
      de_en       = 1'b1;
      de_flush    = 1'b0;
      em_en       = 1'b1;
      mw_en       = 1'b1;
      branch_go_s = 1'b0;
      if (freeze_s) begin
         pc_en = 1'b0;
         fd_en = 1'b0;
         de_en = 1'b0;
         em_en = 1'b0;
         mw_en = 1'b0;
      end else if (branch_ex) begin
         // Redirect overrides both a pending fetch and a load-use on the flushed consumer.
         fd_flush    = 1'b1;
         de_flush    = 1'b1;
         branch_go_s = 1'b1;
      end else if (lu_s) begin
         pc_en    = 1'b0;
         fd_en    = 1'b0;
         de_flush = 1'b1;
      end else if (!ihit) begin
         pc_en    = 1'b0;
         fd_flush = 1'b1;
      end else begin
         pc_en = 1'b1;
      end
   end

   // Wait/halt state, sticky halt flag and saturating performance counters.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_r   <= RUN;
         halted    <= 1'b0;
         stall_cnt <= {CNT_W{1'b0}};
         flush_cnt <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            RUN, DWAIT: begin
               if (halt_wb) begin
                  state_r <= HALT;
                  halted  <= 1'b1;
               end else if (wait_s) begin
                  state_r <= DWAIT;
               end else begin
                  state_r <= RUN;
               end
               if (!pc_en && (stall_cnt != cnt_max_s)) begin
                  stall_cnt <= stall_cnt + cnt_one_s;
               end
               if (branch_go_s && (flush_cnt != cnt_max_s)) begin
                  flush_cnt <= flush_cnt + cnt_one_s;
               end
            end
            HALT: begin
               state_r <= HALT;
               halted  <= 1'b1;
            end
            default: begin
               state_r <= RUN;
               halted  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed plus random bench for hazard_unit; a priority-table reference model
// predicts enables/flushes every cycle and the halt flag and counters after each edge.
module tb_hazard_unit;

   localparam int CW = 4;
   localparam int CMAX = 15;

   logic          CLK = 1'b0;
   logic          RST;
   logic          ihit, dhit, dmemREN_me, dmemWEN_me;
   logic [4:0]    rs_de, rt_de, regDst_ex;
   logic          useRt_de, jr_de, regWr_ex, branch_ex, halt_wb;
   logic [1:0]    regSrc_ex;
   logic          pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en, halted;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit m_wait = 0;
   bit m_halt = 0;
   int m_stall = 0;
   int m_flush = 0;

   hazard_unit #(.CNT_W(CW)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
      .dmemREN_me(dmemREN_me), .dmemWEN_me(dmemWEN_me),
      .rs_de(rs_de), .rt_de(rt_de), .useRt_de(useRt_de), .jr_de(jr_de),
      .regDst_ex(regDst_ex), .regWr_ex(regWr_ex), .regSrc_ex(regSrc_ex),
      .branch_ex(branch_ex), .halt_wb(halt_wb),
      .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_en(de_en),
      .de_flush(de_flush), .em_en(em_en), .mw_en(mw_en), .halted(halted),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Event class: 0 frozen, 1 branch, 2 load-use, 3 fetch miss, 4 normal
   function automatic int classify();
      int dst;
      bit lu;
      dst = int'(regDst_ex);
      lu = regWr_ex && (regSrc_ex == 2'd3) && (dst != 0) &&
           ((int'(rs_de) == dst) || (useRt_de && (int'(rt_de) == dst)));
      if (RST || m_halt || halt_wb) return 0;
      if (!dhit && (m_wait || dmemREN_me || dmemWEN_me)) return 0;
      if (branch_ex) return 1;
      if (lu) return 2;
      if (!ihit) return 3;
      return 4;
   endfunction

   // {pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en}
   function automatic logic [6:0] outs_for(input int cls);
      logic [6:0] tbl [5];
      tbl[0] = 7'b0000000;
      tbl[1] = 7'b1111111;
      tbl[2] = 7'b0001111;
      tbl[3] = 7'b0111011;
      tbl[4] = 7'b1101011;
      return tbl[cls];
   endfunction

   task automatic cycle();
      int cls;
      logic [6:0] exp_o;
      #2;
      cls = classify();
      exp_o = outs_for(cls);
      chk("outs", {25'd0, pc_en, fd_en, fd_flush, de_en, de_flush, em_en, mw_en}, {25'd0, exp_o});
      @(posedge CLK);
      if (RST) begin
         m_wait = 0; m_halt = 0; m_stall = 0; m_flush = 0;
      end else if (!m_halt) begin
         if (!exp_o[6] && m_stall < CMAX) m_stall++;
         if (cls == 1 && m_flush < CMAX) m_flush++;
         m_wait = !halt_wb && !dhit && (m_wait || dmemREN_me || dmemWEN_me);
         m_halt = halt_wb;
      end
      #1;
      chk("halted", {31'd0, halted}, {31'd0, m_halt});
      chk("stall_cnt", {28'd0, stall_cnt}, m_stall);
      chk("flush_cnt", {28'd0, flush_cnt}, m_flush);
   endtask

   task automatic idle_inputs();
      ihit = 1'b1; dhit = 1'b1; dmemREN_me = 1'b0; dmemWEN_me = 1'b0;
      rs_de = 5'd0; rt_de = 5'd0; useRt_de = 1'b0; jr_de = 1'b0;
      regDst_ex = 5'd0; regWr_ex = 1'b0; regSrc_ex = 2'b00;
      branch_ex = 1'b0; halt_wb = 1'b0;
   endtask

   task automatic pulse_reset();
      RST = 1'b1;
      cycle();
      RST = 1'b0;
   endtask

   task automatic set_load(input logic [4:0] dst);
      regWr_ex = 1'b1; regSrc_ex = 2'b11; regDst_ex = dst;
   endtask

   initial begin
      idle_inputs();
      RST = 1'b1;
      cycle();
      cycle();
      chk("reset_stall", {28'd0, stall_cnt}, 32'd0);
      RST = 1'b0;
      cycle();

      // lw $2 in EX, decode reads $2 via rs
      set_load(5'd2); rs_de = 5'd2;
      cycle();
      idle_inputs();
      cycle();
      chk("lw_stall_one", {28'd0, stall_cnt}, 32'd1);

      // JR on $31 behind a load, then behind an ALU op
      set_load(5'd31); jr_de = 1'b1; rs_de = 5'd31;
      cycle();
      regSrc_ex = 2'b00;
      cycle();
      chk("jr_stall", {28'd0, stall_cnt}, 32'd2);

      // $0 destination and unused rt never stall; used rt does
      idle_inputs(); set_load(5'd0);
      cycle();
      set_load(5'd7); rs_de = 5'd3; rt_de = 5'd7; useRt_de = 1'b0;
      cycle();
      useRt_de = 1'b1;
      cycle();
      chk("rt_stall", {28'd0, stall_cnt}, 32'd3);

      // 3-cycle data wait then release
      idle_inputs();
      pulse_reset();
      dmemREN_me = 1'b1; dhit = 1'b0;
      repeat (3) cycle();
      dhit = 1'b1;
      cycle();
      chk("dwait_stall", {28'd0, stall_cnt}, 32'd3);
      idle_inputs();

      // Branch beats load-use and fetch miss
      set_load(5'd4); rs_de = 5'd4; ihit = 1'b0; branch_ex = 1'b1;
      cycle();
      chk("branch_flush", {28'd0, flush_cnt}, 32'd1);

      // Branch held during a store wait is applied once on release
      idle_inputs();
      dmemWEN_me = 1'b1; dhit = 1'b0; branch_ex = 1'b1;
      repeat (2) cycle();
      dhit = 1'b1;
      cycle();
      idle_inputs();
      cycle();
      chk("wait_branch_once", {28'd0, flush_cnt}, 32'd2);

      // Halt is absorbing until reset
      halt_wb = 1'b1;
      cycle();
      idle_inputs();
      branch_ex = 1'b1;
      repeat (3) cycle();
      chk("halt_sticky", {31'd0, halted}, 32'd1);
      idle_inputs();
      pulse_reset();
      chk("halt_cleared", {31'd0, halted}, 32'd0);

      // Saturation of the 4-bit stall counter
      set_load(5'd9); rs_de = 5'd9;
      repeat (20) cycle();
      chk("stall_sat", {28'd0, stall_cnt}, 32'd15);
      idle_inputs();
      pulse_reset();

      // Random traffic with small register indices to make hazards common
      for (int i = 0; i < 400; i++) begin
         ihit       = ($urandom_range(0, 3) != 0);
         dhit       = ($urandom_range(0, 2) != 0);
         dmemREN_me = ($urandom_range(0, 3) == 0);
         dmemWEN_me = ($urandom_range(0, 5) == 0);
         rs_de      = 5'($urandom_range(0, 3));
         rt_de      = 5'($urandom_range(0, 3));
         useRt_de   = 1'($urandom_range(0, 1));
         jr_de      = ($urandom_range(0, 7) == 0);
         regDst_ex  = 5'($urandom_range(0, 3));
         regWr_ex   = 1'($urandom_range(0, 1));
         regSrc_ex  = 2'($urandom_range(0, 3));
         branch_ex  = ($urandom_range(0, 4) == 0);
         halt_wb    = ($urandom_range(0, 60) == 0);
         RST        = ($urandom_range(0, 40) == 0);
         cycle();
      end
      RST = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
